exec_muldiv_ctrl: RTL and testbench
===================================

Name: exec_muldiv_ctrl

Overview:
Sequencing controller for the execute stage's multi-cycle multiply/divide path (RV64 M extension: MUL, DIV, DIVU, REM, REMU and their W forms). It accepts one operation from the execute stage and runs an iterative shift-add multiplier or shift-subtract divider for a fixed number of cycles. While it runs, it holds the pipeline busy, then returns a single-cycle done pulse with the result. It sits alongside the single-cycle ALU; the execute stage selects its output instead of aluout when done is high.

Parameters:
WIDTH, 64, datapath width in bits; word (W) operations use WIDTH/2.

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
flush  in  1  abort the in-flight operation (pipeline redirect)
valid_in  in  1  request a new operation
ready  out  1  controller can accept; high only in IDLE
op  in  3  0 MUL, 1 DIV, 2 DIVU, 3 REM, 4 REMU, 5-7 reserved
word  in  1  W-form: operate on the low 32 bits, sign-extend the 32-bit result
a  in  WIDTH  rs1 operand
b  in  WIDTH  rs2 operand
busy  out  1  high in CALC and DONE; execute stage stalls on it
done  out  1  one-cycle pulse; result is valid in this cycle only
result  out  WIDTH  operation result; 0 whenever done is low

Behaviour:
- Reset (async, any state): state=IDLE; ready=1, busy=0, done=0, result=0; all internal registers cleared.
- FSM states: IDLE, CALC, DONE.
- IDLE: ready=1. On valid_in && !flush at a rising edge, latch op, word, a and b.
  - Normal op: go to CALC with the iteration counter set to N, where N = word ? WIDTH/2 : WIDTH.
  - Special case: go directly to DONE with a precomputed result.
- Special cases (detected at accept, latency 1):
  - Divisor = 0: DIV/DIVU quotient = all ones (-1); REM/REMU = dividend.
  - Signed overflow (DIV/REM only, dividend = most-negative, divisor = -1): quotient = dividend, remainder = 0.
  - Reserved op: result 0.
  - With word=1, all checks use the 32-bit operands.
- Operand preparation:
  - word=1: operands are a[31:0] and b[31:0]. Signed ops sign-extend from bit 31; unsigned ops zero-extend.
  - Signed division uses magnitudes plus recorded signs. Quotient sign = sign(a) XOR sign(b); remainder sign = sign(a).
- CALC: one iteration per cycle; the counter decrements each cycle; leave for DONE when the counter reaches 1 on a rising edge.
  - The operation therefore occupies exactly N CALC cycles.
  - MUL: shift-add, low N bits kept.
  - Divide: restoring shift-subtract, one quotient bit per cycle.
- DONE: lasts exactly one cycle; done=1 and result is driven; then unconditionally returns to IDLE.
  - Final sign correction and the word-form sign-extension (bit 31 replicated into [WIDTH-1:32]) are combinational in DONE.
- Latency from accept edge to the done cycle:
  - N+1 cycles for a normal op (65 for a 64-bit op, 33 for a W op).
  - 1 cycle for a special case.
- Back-to-back: a new valid_in is accepted only when ready=1. The earliest next accept is the edge ending the cycle after DONE, so there is no overlap.
- flush:
  - In CALC or DONE: next state is IDLE, done is forced to 0 in that cycle, and the result is discarded.
  - In IDLE: overrides valid_in; nothing is accepted.
- valid_in while busy is ignored. Operands may change after acceptance without effect.
- Reset asserted mid-CALC: immediate return to IDLE with no done pulse.

Test Plan:
- MUL word=0, a=0x0000000100000003, b=5 -> done at cycle 65 after accept; result=0x000000050000000F; busy high for 65 cycles.
- DIV word=0, a=-7 (0xFFFFFFFFFFFFFFF9), b=2 -> result=-3 (0xFFFFFFFFFFFFFFFD); REM on the same operands -> result=-1 (0xFFFFFFFFFFFFFFFF); each done at cycle 65.
- DIVU word=1, a=0xDEAD0000FFFFFFFF, b=0x10 -> 32-bit quotient 0x0FFFFFFF; result=0x000000000FFFFFFF; done at cycle 33.
- Special cases, each with done 1 cycle after accept:
  - DIVU b=0 -> result=0xFFFFFFFFFFFFFFFF.
  - REM b=0, a=42 -> result=42.
  - DIV a=0x8000000000000000, b=-1 -> result=0x8000000000000000.
  - DIV word=1, a=0x80000000, b=0xFFFFFFFF -> result=0xFFFFFFFF80000000.
- Accept DIV, assert flush at CALC cycle 10 -> IDLE next cycle, no done pulse, ready=1. Then issue MUL 3*4 -> result=12 with correct timing.
- Hold valid_in high continuously with changing operands during an operation -> the first result is unaffected; the second op is accepted on the edge after the done cycle.
- Assert reset mid-CALC -> busy=0, done=0 and result=0 immediately (async).

Source files
------------

// File: rtl/exec_muldiv_ctrl.sv
// Iterative multiply/divide sequencer for the execute stage (RV64 M: MUL, DIV[U], REM[U], W forms).
// One iteration per cycle; special divide cases complete one cycle after accept.
module exec_muldiv_ctrl #(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             valid_in,
    output logic             ready,
    input  logic [2:0]       op,
    input  logic             word,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);
    localparam int unsigned HALF = WIDTH / 2;
    localparam int unsigned CNTW = $clog2(WIDTH + 1);

    localparam logic [2:0] OP_MUL  = 3'd0;
    localparam logic [2:0] OP_DIV  = 3'd1;
    localparam logic [2:0] OP_DIVU = 3'd2;
    localparam logic [2:0] OP_REM  = 3'd3;
    localparam logic [2:0] OP_REMU = 3'd4;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t state, stateNext;

    logic [2:0]       opReg;
    logic             wordReg;
    logic             specialReg;
    logic [WIDTH-1:0] specReg;
    logic             negQ, negR;
    logic [WIDTH-1:0] accReg;   // product or partial remainder
    logic [WIDTH-1:0] xReg;     // multiplier or dividend/quotient
    logic [WIDTH-1:0] yReg;     // multiplicand or divisor
    logic [CNTW-1:0]  cnt;

    logic             accept;
    logic             isMul, isSigned, isQuot, isReserved;
    logic [WIDTH-1:0] aExt, bExt, aMag, bMag, minNeg, specVal;
    logic             aNeg, bNeg, divZero, divOvf, isSpecial;
    logic [WIDTH:0]   divShift;
    logic             qBit;
    logic [WIDTH-1:0] divRem;
    logic [WIDTH-1:0] rawRes;

    // Operand preparation and special-case detection at accept
    always_comb begin
        isMul      = (op == OP_MUL);
        isSigned   = (op == OP_DIV) || (op == OP_REM);
        isQuot     = (op == OP_DIV) || (op == OP_DIVU);
        isReserved = (op > OP_REMU);
        if (word) begin
            aExt   = isSigned ? {{HALF{a[HALF-1]}}, a[HALF-1:0]} : {{HALF{1'b0}}, a[HALF-1:0]};
            bExt   = isSigned ? {{HALF{b[HALF-1]}}, b[HALF-1:0]} : {{HALF{1'b0}}, b[HALF-1:0]};
            minNeg = {{HALF{1'b1}}, 1'b1, {(HALF-1){1'b0}}};
        end else begin
            aExt   = a;
            bExt   = b;
            minNeg = {1'b1, {(WIDTH-1){1'b0}}};
        end
        aNeg    = isSigned && aExt[WIDTH-1];
        bNeg    = isSigned && bExt[WIDTH-1];
        aMag    = aNeg ? -aExt : aExt;
        bMag    = bNeg ? -bExt : bExt;
        divZero = (bExt == '0);
        divOvf  = isSigned && (aExt == minNeg) && (bExt == '1);
        specVal = '0;
        if (!isMul && !isReserved) begin
            if (divZero)
                specVal = isQuot ? '1 : aExt;
            else if (divOvf)
                specVal = isQuot ? aExt : '0;
        end
        isSpecial = isReserved || (!isMul && (divZero || divOvf));
    end

    // Restoring divide step
    always_comb begin
        divShift = {accReg, xReg[WIDTH-1]};
        qBit     = (divShift >= {1'b0, yReg});
        divRem   = qBit ? WIDTH'(divShift - {1'b0, yReg}) : divShift[WIDTH-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= stateNext;
    end

    // Next state and control outputs
    always_comb begin
        stateNext = state;
        accept    = 1'b0;
        ready     = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (valid_in && !flush) begin
                    accept    = 1'b1;
                    stateNext = isSpecial ? DONE : CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (flush)
                    stateNext = IDLE;
                else if (cnt == CNTW'(1))
                    stateNext = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                done      = !flush;
                stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            opReg      <= '0;
            wordReg    <= 1'b0;
            specialReg <= 1'b0;
            specReg    <= '0;
            negQ       <= 1'b0;
            negR       <= 1'b0;
            accReg     <= '0;
            xReg       <= '0;
            yReg       <= '0;
            cnt        <= '0;
        end else if (accept) begin
            opReg      <= op;
            wordReg    <= word;
            specialReg <= isSpecial;
            specReg    <= specVal;
            negQ       <= aNeg ^ bNeg;
            negR       <= aNeg;
            accReg     <= '0;
            cnt        <= word ? CNTW'(HALF) : CNTW'(WIDTH);
            if (isMul) begin
                xReg <= bExt;
                yReg <= aExt;
            end else begin
                // W divides start with the dividend MSB-aligned so the step logic is width-agnostic
                xReg <= word ? (aMag << HALF) : aMag;
                yReg <= bMag;
            end
        end else if (state == CALC) begin
            cnt <= cnt - CNTW'(1);
            if (opReg == OP_MUL) begin
                if (xReg[0])
                    accReg <= accReg + yReg;
                xReg <= xReg >> 1;
                yReg <= yReg << 1;
            end else begin
                accReg <= divRem;
                xReg   <= {xReg[WIDTH-2:0], qBit};
            end
        end
    end

    // Sign correction and W-form extension, visible only while done
    always_comb begin
        case (opReg)
            OP_MUL:          rawRes = accReg;
            OP_DIV, OP_DIVU: rawRes = negQ ? -xReg : xReg;
            OP_REM, OP_REMU: rawRes = negR ? -accReg : accReg;
            default:         rawRes = '0;
        endcase
        if (specialReg)
            rawRes = specReg;
        if (wordReg)
            rawRes = {{HALF{rawRes[HALF-1]}}, rawRes[HALF-1:0]};
        result = done ? rawRes : '0;
    end

endmodule

// File: tb/tb_exec_muldiv_ctrl.sv
// Directed bench for exec_muldiv_ctrl: latency, results, special cases, flush and reset.
module tb_exec_muldiv_ctrl;
    localparam int unsigned WIDTH = 64;
    localparam int LIMIT = 200;

    logic             clk = 1'b0;
    logic             reset, flush, valid_in, word;
    logic [2:0]       op;
    logic [WIDTH-1:0] a, b;
    logic             ready, busy, done;
    logic [WIDTH-1:0] result;

    int nChecks = 0;
    int nFail   = 0;

    exec_muldiv_ctrl #(.WIDTH(WIDTH)) dut (
        .clk(clk), .reset(reset), .flush(flush), .valid_in(valid_in), .ready(ready),
        .op(op), .word(word), .a(a), .b(b), .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called one step after the accept edge; counts edges until done (bounded)
    task automatic waitDone(output int lat, output int busyCnt);
        lat     = 1;
        busyCnt = busy ? 1 : 0;
        while (!done && lat < LIMIT) begin
            @(posedge clk); #1;
            lat++;
            if (busy) busyCnt++;
        end
    endtask

    task automatic runOp(input string tag, input logic [2:0] o, input logic w,
                         input logic [63:0] x, input logic [63:0] y,
                         input logic [63:0] expRes, input int expLat);
        int lat, busyCnt;
        @(negedge clk);
        op = o; word = w; a = x; b = y; valid_in = 1'b1;
        @(posedge clk); #1;
        valid_in = 1'b0;
        a = '1; b = '1;
        waitDone(lat, busyCnt);
        checkEq({tag, ".lat"}, 64'(lat), 64'(expLat));
        checkEq({tag, ".res"}, result, expRes);
        checkEq({tag, ".busy"}, 64'(busyCnt), 64'(expLat));
        @(posedge clk); #1;
        checkEq({tag, ".after"}, {61'd0, ready, busy, done}, 64'b100);
    endtask

    initial begin
        int lat, busyCnt;
        reset = 1'b1; flush = 1'b0; valid_in = 1'b0; word = 1'b0; op = '0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        checkEq("reset.ctl", {61'd0, ready, busy, done}, 64'b100);
        checkEq("reset.res", result, 64'd0);
        @(negedge clk); reset = 1'b0;

        runOp("mul64", 3'd0, 1'b0, 64'h0000000100000003, 64'd5, 64'h000000050000000F, 65);
        runOp("div_neg", 3'd1, 1'b0, 64'hFFFFFFFFFFFFFFF9, 64'd2, 64'hFFFFFFFFFFFFFFFD, 65);
        runOp("rem_neg", 3'd3, 1'b0, 64'hFFFFFFFFFFFFFFF9, 64'd2, 64'hFFFFFFFFFFFFFFFF, 65);
        runOp("divuw", 3'd2, 1'b1, 64'hDEAD0000FFFFFFFF, 64'h10, 64'h000000000FFFFFFF, 33);
        runOp("remu", 3'd4, 1'b0, 64'd100, 64'd7, 64'd2, 65);
        runOp("divu_z", 3'd2, 1'b0, 64'd123, 64'd0, 64'hFFFFFFFFFFFFFFFF, 1);
        runOp("rem_z", 3'd3, 1'b0, 64'd42, 64'd0, 64'd42, 1);
        runOp("div_ovf", 3'd1, 1'b0, 64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF, 64'h8000000000000000, 1);
        runOp("divw_ovf", 3'd1, 1'b1, 64'h0000000080000000, 64'h00000000FFFFFFFF, 64'hFFFFFFFF80000000, 1);
        runOp("rsvd", 3'd5, 1'b0, 64'd9, 64'd3, 64'd0, 1);

        // flush in IDLE overrides valid_in
        @(negedge clk);
        op = 3'd0; a = 64'd2; b = 64'd2; valid_in = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        valid_in = 1'b0; flush = 1'b0;
        checkEq("flush_idle", {61'd0, ready, busy, done}, 64'b100);

        // flush during CALC cycle 10
        @(negedge clk);
        op = 3'd1; word = 1'b0; a = 64'd1000; b = 64'd3; valid_in = 1'b1;
        @(posedge clk); #1;
        valid_in = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        checkEq("calc.res0", result, 64'd0);
        flush = 1'b1;
        #1;
        checkEq("flush.done", {63'd0, done}, 64'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        checkEq("flush.idle", {61'd0, ready, busy, done}, 64'b100);
        runOp("mul_post", 3'd0, 1'b0, 64'd3, 64'd4, 64'd12, 65);

        // valid_in held high with changing operands
        @(negedge clk);
        op = 3'd0; word = 1'b0; a = 64'd6; b = 64'd7; valid_in = 1'b1;
        @(posedge clk); #1;
        fork
            waitDone(lat, busyCnt);
            repeat (40) begin
                @(negedge clk);
                op = 3'($urandom_range(0, 4));
                a = {$urandom, $urandom};
                b = {$urandom, $urandom};
            end
        join
        checkEq("b2b1.lat", 64'(lat), 64'd65);
        checkEq("b2b1.res", result, 64'd42);
        op = 3'd0; a = 64'd9; b = 64'd9;
        @(posedge clk); #1;
        checkEq("b2b.gap", {61'd0, ready, busy, done}, 64'b100);
        @(posedge clk); #1;
        checkEq("b2b2.acc", {61'd0, ready, busy, done}, 64'b010);
        valid_in = 1'b0;
        waitDone(lat, busyCnt);
        checkEq("b2b2.lat", 64'(lat), 64'd65);
        checkEq("b2b2.res", result, 64'd81);

        // asynchronous reset mid-CALC
        @(posedge clk); #1;
        runOp("pre_rst", 3'd4, 1'b1, 64'd17, 64'd5, 64'd2, 33);
        @(negedge clk);
        op = 3'd0; a = 64'd5; b = 64'd5; valid_in = 1'b1;
        @(posedge clk); #1;
        valid_in = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        checkEq("rst.ctl", {61'd0, ready, busy, done}, 64'b100);
        checkEq("rst.res", result, 64'd0);
        @(negedge clk); reset = 1'b0;
        runOp("post_rst", 3'd2, 1'b0, 64'd5, 64'd0, 64'hFFFFFFFFFFFFFFFF, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end
endmodule
